// File: rtl/lsic_param.sv
// Parametrised interrupt controller: per-source level/edge latching, disable and
// priority-limit filtering, lowest-index resolver and an AXI4-Lite register port.
module lsic_param #(
  parameter int          NUM_IRQS    = 64,
  parameter logic [31:0] BASE_ADDR   = 32'hF803_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IRQS-1:0]         irqs,
  output logic                        cpu_irq,
  output logic [$clog2(NUM_IRQS)-1:0] claim_id,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [31:0]                 s_axi_awaddr,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  input  logic [31:0]                 s_axi_wdata,
  input  logic [3:0]                  s_axi_wstrb,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  output logic [1:0]                  s_axi_bresp,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  input  logic [31:0]                 s_axi_araddr,
  output logic                        s_axi_rvalid,
  output logic                        s_axi_rlast,
  input  logic                        s_axi_rready,
  output logic [31:0]                 s_axi_rdata,
  output logic [1:0]                  s_axi_rresp
);

  localparam int NB   = NUM_IRQS / 32;
  localparam int IW   = $clog2(NUM_IRQS);
  localparam int IPLW = IW + 1;

  typedef enum logic [1:0] {S_READY, S_RD, S_WDATA, S_WRESP} state_e;
  typedef enum logic [2:0] {R_DISA, R_PEND, R_PCLR, R_EDGE, R_CLAIM, R_IPL, R_NONE} reg_e;

  // Word offset within the window: [9:5] selects a 128-byte region, [4:0] the bank.
  function automatic reg_e decode(input logic [9:0] w);
    reg_e r;
    logic bank_ok;
    bank_ok = int'(w[4:0]) < NB;
    case (w[9:5])
      5'd0:    r = bank_ok ? R_DISA : R_NONE;
      5'd2:    r = bank_ok ? R_PEND : R_NONE;
      5'd3:    r = bank_ok ? R_PCLR : R_NONE;
      5'd4:    r = bank_ok ? R_EDGE : R_NONE;
      5'd6:    r = (w[4:0] == 5'd0) ? R_CLAIM : (w[4:0] == 5'd1) ? R_IPL : R_NONE;
      default: r = R_NONE;
    endcase
    return r;
  endfunction

  state_e                         state_q;
  logic                           ready_q, wready_q, bvalid_q, rvalid_q;
  logic [1:0]                     bresp_q, rresp_q;
  logic [31:0]                    rdata_q;
  logic [9:0]                     off_q;

  logic [NUM_IRQS-1:0]            pend_q, pend_d;
  logic [NUM_IRQS-1:0]            irq_prev_q;
  logic [NUM_IRQS-1:0]            disa_q, disa_d;
  logic [NUM_IRQS-1:0]            edge_q, edge_d;
  logic [IPLW-1:0]                ipl_q, ipl_d;
  logic [SYNC_STAGES-1:0]         vld_q, vld_d;
  logic [SYNC_STAGES-1:0][IW-1:0] id_q, id_d;

  logic [NUM_IRQS-1:0]            sw_set, sw_clr, set_term, elig;
  logic                           res_vld;
  logic [IW-1:0]                  res_id;

  logic                           ar_hit, aw_hit, ar_take, aw_take;
  logic                           w_fire, wr_err, wr_ok, rd_err;
  reg_e                           rd_kind, wr_kind;
  logic [31:0]                    rd_data;

  assign ar_hit  = s_axi_araddr[31:12] == BASE_ADDR[31:12];
  assign aw_hit  = s_axi_awaddr[31:12] == BASE_ADDR[31:12];
  // A pending in-window read takes priority over a simultaneous write.
  assign ar_take = (state_q == S_READY) && ready_q && s_axi_arvalid && ar_hit;
  assign aw_take = (state_q == S_READY) && ready_q && s_axi_awvalid && aw_hit &&
                   !(s_axi_arvalid && ar_hit);

  assign s_axi_arready = ready_q & ar_hit;
  assign s_axi_awready = ready_q & aw_hit & ~(s_axi_arvalid & ar_hit);
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = 1'b1;

  assign cpu_irq  = vld_q[SYNC_STAGES-1];
  assign claim_id = id_q[SYNC_STAGES-1];

  assign rd_kind = decode(off_q);
  assign wr_kind = decode(off_q);
  assign w_fire  = (state_q == S_WDATA) && wready_q && s_axi_wvalid;
  assign wr_err  = (wr_kind == R_NONE) || (s_axi_wstrb != 4'hF);
  assign wr_ok   = w_fire && !wr_err;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    disa_d = disa_q;
    edge_d = edge_q;
    ipl_d  = ipl_q;
    sw_set = '0;
    sw_clr = '0;
    if (wr_ok) begin
      for (int k = 0; k < NB; k++) begin
        if (off_q[4:0] == 5'(k)) begin
          case (wr_kind)
            R_DISA:  disa_d[32*k +: 32] = s_axi_wdata;
            R_PEND:  sw_set[32*k +: 32] = s_axi_wdata;
            R_PCLR:  sw_clr[32*k +: 32] = s_axi_wdata;
            R_EDGE:  edge_d[32*k +: 32] = s_axi_wdata;
            default: ;
          endcase
        end
      end
      if (wr_kind == R_CLAIM) begin
        for (int i = 0; i < NUM_IRQS; i++) begin
          if (s_axi_wdata[7:0] == 8'(i)) sw_clr[i] = 1'b1;
        end
      end
      if (wr_kind == R_IPL) ipl_d = s_axi_wdata[IPLW-1:0];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_kind)
      R_DISA, R_PEND, R_EDGE: begin
        for (int k = 0; k < NB; k++) begin
          if (off_q[4:0] == 5'(k)) begin
            if (rd_kind == R_DISA)      rd_data = disa_q[32*k +: 32];
            else if (rd_kind == R_PEND) rd_data = pend_q[32*k +: 32];
            else                        rd_data = edge_q[32*k +: 32];
          end
        end
      end
      R_PCLR:  rd_data = '0;
      R_CLAIM: rd_data = {vld_q[SYNC_STAGES-1], 23'd0, 8'(id_q[SYNC_STAGES-1])};
      R_IPL:   rd_data = 32'(ipl_q);
      default: rd_err  = 1'b1;
    endcase
  end

  // Hardware set term is OR'd last so it beats a same-cycle software clear.
  always_comb begin
    set_term = irqs & ~(edge_q & irq_prev_q);
    pend_d   = (pend_q & ~sw_clr) | sw_set | set_term;
    res_vld  = 1'b0;
    res_id   = '0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      elig[i] = pend_q[i] & ~disa_q[i] & (IPLW'(i) < ipl_q);
      if (!res_vld && elig[i]) begin
        res_vld = 1'b1;
        res_id  = IW'(i);
      end
    end
    vld_d[0] = res_vld;
    id_d[0]  = res_id;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      vld_d[s] = vld_q[s-1];
      id_d[s]  = id_q[s-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so flop order never matters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      irq_prev_q <= '0;
      disa_q     <= '0;
      edge_q     <= '0;
      ipl_q      <= '0;
      vld_q      <= '0;
      id_q       <= '0;
    end else begin
      pend_q     <= pend_d;
      irq_prev_q <= irqs;
      disa_q     <= disa_d;
      edge_q     <= edge_d;
      ipl_q      <= ipl_d;
      vld_q      <= vld_d;
      id_q       <= id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_READY;
      ready_q  <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
      off_q    <= '0;
    end else begin
      case (state_q)
        S_READY: begin
          if (ar_take) begin
            ready_q <= 1'b0;
            off_q   <= s_axi_araddr[11:2];
            state_q <= S_RD;
          end else if (aw_take) begin
            ready_q  <= 1'b0;
            wready_q <= 1'b1;
            off_q    <= s_axi_awaddr[11:2];
            state_q  <= S_WDATA;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_RD: begin
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_err ? 2'b10 : 2'b00;
          end else if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= S_READY;
          end
        end
        S_WDATA: begin
          if (w_fire) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_err ? 2'b10 : 2'b00;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (s_axi_bready) begin
            bvalid_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= S_READY;
          end
        end
        default: state_q <= S_READY;
      endcase
    end
  end

endmodule
